spi_master: RTL
===============

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter DATA_W, default 8, transfer word width in bits.
REQ-002 Parameter NUM_SS, default 2, number of slave-select lines.
REQ-003 Parameter DIV_W, default 16, width of the clock divisor.
REQ-004 clk  input  1  system clock; the block uses this one clock only.
REQ-005 resetn  input  1  reset, synchronous to clk and active-low.
REQ-006 dvsr  input  DIV_W  half-period divisor; each SCLK half-period lasts dvsr+1 clk cycles.
REQ-007 cpol  input  1  SCLK idle level.
REQ-008 cpha  input  1  clock phase: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-009 start  input  1  transfer request; accepted only when ready=1.
REQ-010 tx_data  input  DATA_W  word to shift out, MSB first.
REQ-011 ss_assert  input  NUM_SS  slave-select request; 1 = select.
REQ-012 ready  output  1  high when the block is idle and can accept start.
REQ-013 done  output  1  one-cycle pulse at the end of a transfer.
REQ-014 rx_data  output  DATA_W  received word; valid from done until the next accepted start.
REQ-015 spi_clk  output  1  SPI serial clock.
REQ-016 spi_mosi  output  1  serial data out.
REQ-017 spi_miso  input  1  serial data in.
REQ-018 spi_ss_n  output  NUM_SS  active-low slave selects.

Function
REQ-019 FSM states: IDLE, DELAY, P0, P1; ready = (state==IDLE).
REQ-020 start is accepted in IDLE. On acceptance:
- dvsr, cpol, cpha and tx_data are latched into internal registers.
- bit counter and half-period counter clear.
- spi_mosi = tx_data[DATA_W-1] from the next cycle.
- next state is DELAY if cpha=1, otherwise P0.
REQ-021 start is ignored outside IDLE; input changes during a transfer have no effect.
REQ-022 The half-period counter increments every cycle in DELAY, P0 and P1; a half-period ends when the count equals the latched dvsr, and the counter then clears.
REQ-023 DELAY ends after one half-period and moves to P0.
REQ-024 At the end of P0, spi_miso is sampled into the shift register LSB (left shift), then the state moves to P1.
REQ-025 At the end of P1:
- if bit count = DATA_W-1, go to IDLE and pulse done for one cycle, with rx_data holding the full received word in that cycle;
- otherwise shift the tx register left, drive the next bit on spi_mosi, increment the bit count and go to P0.
REQ-026 spi_clk is registered and equals latched cpol XOR active, where active = (state==P1) if cpha=0 and (state==P0) if cpha=1; in IDLE and DELAY spi_clk = latched cpol.
REQ-027 Latency from the accepting cycle to the done pulse is 2*DATA_W*(dvsr+1) cycles for cpha=0 and (2*DATA_W+1)*(dvsr+1) for cpha=1, with ±0 tolerance.
REQ-028 dvsr=0 is legal: half-period is 1 cycle and SCLK = clk/2.
REQ-029 spi_ss_n = ~ss_assert, registered with 1-cycle latency and independent of the FSM; the block does not sequence SS.
REQ-030 start asserted in the cycle done pulses is accepted, since state is IDLE in that cycle.

Reset
REQ-031 On resetn=0 at a clk edge:
- state goes to IDLE and all counters clear;
- latched cpol = 0 and cpha = 0;
- spi_clk = 0, spi_mosi = 0, spi_ss_n = all 1s;
- done = 0, rx_data = 0, ready = 1 after release.
REQ-032 Reset mid-transfer aborts the transfer with no done pulse; the first start after release behaves as a fresh transfer.

Structure
REQ-033 Shared package spi_pkg holds the FSM state encoding (IDLE, DELAY, P0, P1) and the default DATA_W, NUM_SS and DIV_W constants.
REQ-034 A single sub-module, spi_halfcycle_cnt (DIV_W counter with clear and terminal-count output), is instantiated once; all other logic is in spi_master.

Verification
REQ-035 Mode 0, dvsr=3, spi_miso looped to spi_mosi, tx_data=0xA5 -> done exactly 64 cycles after acceptance, rx_data=0xA5, spi_clk idles 0, 8 rising edges.
REQ-036 Mode 3 (cpol=1, cpha=1), dvsr=1, spi_miso tied 1, tx_data=0x3C -> done 34 cycles after acceptance, rx_data=0xFF, spi_clk idles 1, MOSI bits 0,0,1,1,1,1,0,0.
REQ-037 Mode 1, dvsr=0, slave model returns 0x5A on trailing edges -> rx_data=0x5A, done 17 cycles after acceptance, SCLK period 2 cycles.
REQ-038 start pulsed with tx_data=0xFF during a transfer of 0x12 -> ignored; exactly one done, MOSI carries 0x12.
REQ-039 resetn low for 1 cycle at bit 4 of a transfer -> no done, spi_clk=0, spi_ss_n=2'b11, ready=1 next cycle; a following 0xC3 loopback transfer gives rx_data=0xC3.
REQ-040 ss_assert=2'b10 -> spi_ss_n=2'b01 one cycle later, unaffected by back-to-back transfers with start asserted in the done cycle.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI master constants, FSM encoding and SCLK level helper
package spi_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int NUM_SS_DEF = 2;
  localparam int DIV_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_P0    = 2'd2,
    ST_P1    = 2'd3
  } spi_state_e;

  // SCLK leaves its idle level in P1 for cpha=0 and in P0 for cpha=1
  function automatic logic sclk_level(input logic cpol, input logic cpha, input spi_state_e st);
    logic active;
    active = cpha ? (st == ST_P0) : (st == ST_P1);
    return cpol ^ active;
  endfunction

endpackage

// File: rtl/spi_halfcycle_cnt.sv
// rtl/spi_halfcycle_cnt.sv - half-period counter with synchronous clear and terminal count
module spi_halfcycle_cnt #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] limit_i,
  output logic             tc_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && (cnt_q == limit_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tc_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI master, all four modes, programmable SCLK divisor, MSB first
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_SS = NUM_SS_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DIV_W-1:0]  dvsr,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [NUM_SS-1:0] ss_assert,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_SS-1:0] spi_ss_n
);

  localparam int BIT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  spi_state_e        state_q;
  logic [DIV_W-1:0]  dvsr_q;
  logic              cpol_q, cpha_q;
  logic [DATA_W-2:0] tx_q;
  logic [DATA_W-1:0] rx_q;
  logic [BIT_W-1:0]  bit_q;
  logic              mosi_q, sclk_q, done_q;
  logic [NUM_SS-1:0] ss_n_q;
  logic              accept, half_tc;

  assign accept = (state_q == ST_IDLE) && start;

  spi_halfcycle_cnt #(.DIV_W(DIV_W)) u_half_cnt (
    .clk     (clk),
    .resetn  (resetn),
    .clr_i   (accept),
    .en_i    (state_q != ST_IDLE),
    .limit_i (dvsr_q),
    .tc_o    (half_tc)
  );

  // tx_q holds only the bits not yet on spi_mosi, so its MSB is always the next bit
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      dvsr_q  <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      bit_q   <= '0;
      mosi_q  <= 1'b0;
      sclk_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            dvsr_q  <= dvsr;
            cpol_q  <= cpol;
            cpha_q  <= cpha;
            tx_q    <= tx_data[DATA_W-2:0];
            bit_q   <= '0;
            mosi_q  <= tx_data[DATA_W-1];
            state_q <= cpha ? ST_DELAY : ST_P0;
            sclk_q  <= sclk_level(cpol, cpha, cpha ? ST_DELAY : ST_P0);
          end
        end
        ST_DELAY: begin
          if (half_tc) begin
            state_q <= ST_P0;
            sclk_q  <= sclk_level(cpol_q, cpha_q, ST_P0);
          end
        end
        ST_P0: begin
          if (half_tc) begin
            rx_q    <= {rx_q[DATA_W-2:0], spi_miso};
            state_q <= ST_P1;
            sclk_q  <= sclk_level(cpol_q, cpha_q, ST_P1);
          end
        end
        ST_P1: begin
          if (half_tc) begin
            if (bit_q == BIT_W'(DATA_W-1)) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
              sclk_q  <= cpol_q;
            end else begin
              mosi_q  <= tx_q[DATA_W-2];
              tx_q    <= tx_q << 1;
              bit_q   <= bit_q + BIT_W'(1);
              state_q <= ST_P0;
              sclk_q  <= sclk_level(cpol_q, cpha_q, ST_P0);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ss_n_q <= '1;
    end else begin
      ss_n_q <= ~ss_assert;
    end
  end

  assign ready    = (state_q == ST_IDLE);
  assign done     = done_q;
  assign rx_data  = rx_q;
  assign spi_clk  = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_ss_n = ss_n_q;

endmodule
